// File: rtl/bch_gf16_pkg.sv
// GF(2^4) helpers and constants for the BCH(15,k) t=3 decoder chain (poly x^4+x+1).
// The exponent tables are shared with the downstream key-equation/Chien stage.
package bch_gf16_pkg;
   localparam int          N             = 15;
   localparam int          NSYN          = 6;
   localparam logic [4:0]  GF16_POLY     = 5'b10011;
   localparam logic [3:0]  GF16_ZERO_EXP = 4'hF;

   typedef enum logic [1:0] {IDLE, ACC, OUT} syn_state_t;

   // Multiply by alpha: shift left, fold x^4 back as x+1.
   function automatic logic [3:0] gf_mul_alpha(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ (GF16_POLY[3:0] & {4{x[3]}});
   endfunction

   // Constant multiply by alpha^p; p is an elaboration constant, so this flattens to XORs.
   function automatic logic [3:0] gf_mul_alpha_pow(input logic [3:0] x, input int unsigned p);
      logic [3:0] r;
      r = x;
      for (int unsigned i = 0; i < p; i++) r = gf_mul_alpha(r);
      return r;
   endfunction

   function automatic logic [3:0] gf_exp2int(input logic [3:0] e);
      case (e)
         4'd0:  return 4'd1;   4'd1:  return 4'd2;   4'd2:  return 4'd4;
         4'd3:  return 4'd8;   4'd4:  return 4'd3;   4'd5:  return 4'd6;
         4'd6:  return 4'd12;  4'd7:  return 4'd11;  4'd8:  return 4'd5;
         4'd9:  return 4'd10;  4'd10: return 4'd7;   4'd11: return 4'd14;
         4'd12: return 4'd15;  4'd13: return 4'd13;  4'd14: return 4'd9;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] gf_int2exp(input logic [3:0] v);
      case (v)
         4'd1:  return 4'd0;   4'd2:  return 4'd1;   4'd3:  return 4'd4;
         4'd4:  return 4'd2;   4'd5:  return 4'd8;   4'd6:  return 4'd5;
         4'd7:  return 4'd10;  4'd8:  return 4'd3;   4'd9:  return 4'd14;
         4'd10: return 4'd9;   4'd11: return 4'd7;   4'd12: return 4'd6;
         4'd13: return 4'd13;  4'd14: return 4'd11;  4'd15: return 4'd12;
         default: return GF16_ZERO_EXP;
      endcase
   endfunction
endpackage

// File: rtl/bch_syndrome_gen_if.sv
// Serial received-word input and exponent-form syndrome stream of the syndrome stage.
interface bch_syndrome_gen_if;
   logic       in_valid;
   logic       in_bit;
   logic       out_valid;
   logic [3:0] out_syndrome;
   logic       out_no_error;

   modport master (output in_valid, in_bit, input out_valid, out_syndrome, out_no_error);
   modport slave  (input in_valid, in_bit, output out_valid, out_syndrome, out_no_error);
endinterface

// File: rtl/bch_syndrome_gen_syn_cell.sv
// One Horner accumulator: acc <= acc*alpha^J + in_bit, or loaded with in_bit on the first bit.
module bch_syn_cell
   import bch_gf16_pkg::*;
#(
   parameter int unsigned J = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic       in_bit,
   output logic [3:0] acc,
   output logic [3:0] acc_nxt
);
   assign acc_nxt = gf_mul_alpha_pow(acc, J) ^ {3'b000, in_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    acc <= 4'd0;
      else if (load) acc <= {3'b000, in_bit};
      else if (en)   acc <= acc_nxt;
   end
endmodule

// File: rtl/bch_syndrome_gen.sv
// Serial syndrome generator: six Horner cells, then an exponent-form stream S6..S1.
module bch_syndrome_gen
   import bch_gf16_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   bch_syndrome_gen_if.slave   bus
);
   syn_state_t             state, nxt;
   logic                   load, en;
   logic [3:0]             cnt;
   logic [2:0]             ocnt, sel;
   logic                   no_err;
   logic [NSYN-1:0][3:0]   acc, acc_nxt;

   for (genvar g = 0; g < NSYN; g++) begin : g_cell
      bch_syn_cell #(.J(g + 1)) u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load),
         .en      (en),
         .in_bit  (bus.in_bit),
         .acc     (acc[g]),
         .acc_nxt (acc_nxt[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt  = state;
      load = 1'b0;
      en   = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            load = 1'b1;
            nxt  = ACC;
         end
         ACC: if (bus.in_valid) begin
            en = 1'b1;
            if (cnt == 4'(N - 1)) nxt = OUT;
         end else begin
            nxt = IDLE;
         end
         OUT: if (ocnt == 3'(NSYN - 1)) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // The zero flag looks at the accumulator values being written on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 4'd0;
         ocnt   <= 3'd0;
         no_err <= 1'b0;
      end else begin
         if (load)              cnt <= 4'd1;
         else if (en)           cnt <= cnt + 4'd1;
         else if (state != ACC) cnt <= 4'd0;

         if (state == OUT) ocnt <= ocnt + 3'd1;
         else              ocnt <= 3'd0;

         if (en && cnt == 4'(N - 1)) no_err <= ~|acc_nxt;
         else if (nxt != OUT)        no_err <= 1'b0;
      end
   end

   assign sel = 3'(NSYN - 1) - ocnt;

   always_comb begin
      bus.out_valid    = 1'b0;
      bus.out_syndrome = 4'd0;
      bus.out_no_error = 1'b0;
      if (state == OUT) begin
         bus.out_valid    = 1'b1;
         bus.out_syndrome = gf_int2exp(acc[sel]);
         bus.out_no_error = no_err;
      end
   end
endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Directed bench for bch_syndrome_gen: hand-computed syndrome streams, abort, back-to-back, reset.
module tb_bch_syndrome_gen;
   typedef logic [3:0] syn6_t [6];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   bch_syndrome_gen_if bus ();

   bch_syndrome_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Sends a full word MSB (r14) first; checks 6 outputs. rst_at >= 0 pulses reset in that out cycle.
   task automatic run_word(input string tag, input logic [14:0] w, input syn6_t es,
                           input logic ene, input int rst_at);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk({tag, "_quiet"}, {3'b0, bus.out_valid}, 4'd0);
         bus.in_valid = 1'b1;
         bus.in_bit   = w[14 - i];
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_valid"}, {3'b0, bus.out_valid}, 4'd0);
            chk({tag, "_rst_syn"}, bus.out_syndrome, 4'd0);
            chk({tag, "_rst_ne"}, {3'b0, bus.out_no_error}, 4'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk({tag, "_post_rst_valid"}, {3'b0, bus.out_valid}, 4'd0);
            return;
         end
         chk($sformatf("%s_valid%0d", tag, k), {3'b0, bus.out_valid}, 4'd1);
         chk($sformatf("%s_syn%0d", tag, k), bus.out_syndrome, es[k]);
         chk($sformatf("%s_ne%0d", tag, k), {3'b0, bus.out_no_error}, {3'b0, ene});
         if (k < 5) @(negedge clk);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_valid", {3'b0, bus.out_valid}, 4'd0);
      chk("reset_syn", bus.out_syndrome, 4'd0);
      chk("reset_ne", {3'b0, bus.out_no_error}, 4'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All zero: every syndrome is the zero element
      run_word("zero", 15'h0000, '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, 1'b1, -1);
      @(negedge clk);
      // Error at r0: S_j = 1 = alpha^0
      run_word("r0", 15'h0001, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, -1);
      @(negedge clk);
      // Error at r1,r0: S_j = alpha^j + 1
      run_word("r1r0", 15'h0003, '{4'd13, 4'd10, 4'd1, 4'd14, 4'd8, 4'd4}, 1'b0, -1);
      @(negedge clk);

      // Abort after 7 bits; nothing may come out
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_bit   = i[0];
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("abort_quiet", {3'b0, bus.out_valid}, 4'd0);
         @(negedge clk);
      end
      run_word("after_abort", 15'h0000, '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, 1'b1, -1);

      // Back-to-back: r14 then r0, no idle gap beyond the mandatory IDLE cycle
      run_word("r14", 15'h4000, '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14}, 1'b0, -1);
      run_word("b2b_r0", 15'h0001, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, -1);

      // Reset during third output cycle truncates the stream
      run_word("rst_mid", 15'h0003, '{4'd13, 4'd10, 4'd1, 4'd14, 4'd8, 4'd4}, 1'b0, 2);
      run_word("after_rst", 15'h0003, '{4'd13, 4'd10, 4'd1, 4'd14, 4'd8, 4'd4}, 1'b0, -1);
      @(negedge clk);
      chk("final_idle", {3'b0, bus.out_valid}, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
